// File: rtl/turn_signal_controller_if.sv
// Switch inputs and lamp/status outputs of the turn signal controller.
// The bench drives through master; the controller attaches as slave.
interface turn_signal_controller_if;
  logic       sw_turn_left;
  logic       sw_turn_right;
  logic       sw_hazard;
  logic       turn_left;
  logic       turn_right;
  logic       tick;
  logic [1:0] mode;

  modport master (
    output sw_turn_left, sw_turn_right, sw_hazard,
    input  turn_left, turn_right, tick, mode
  );

  modport slave (
    input  sw_turn_left, sw_turn_right, sw_hazard,
    output turn_left, turn_right, tick, mode
  );
endinterface

// File: rtl/turn_signal_controller.sv
// Turn/hazard indicator controller: synchronised and debounced switches drive a
// priority FSM whose blink phase restarts on every entry into a lit mode.
module turn_signal_controller #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned HALF_PERIOD  = 25000000
) (
  input logic                     clk,
  input logic                     rst,
  turn_signal_controller_if.slave bus
);

  localparam int unsigned DB_NEED = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned DB_W    = (DB_NEED > 20) ? DB_NEED : 20;
  localparam int unsigned HP_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_e;

  // Bit order for all per-switch vectors: [0]=left, [1]=right, [2]=hazard.
  logic [2:0]            raw;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            deb_q, deb_d;
  logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

  state_e                state_q, state_d;
  logic [HP_W-1:0]       hp_cnt_q, hp_cnt_d;
  logic                  phase_q, phase_d;
  logic                  tick_q, tick_d;
  logic                  tl_q, tl_d;
  logic                  tr_q, tr_d;

  assign raw = {bus.sw_hazard, bus.sw_turn_right, bus.sw_turn_left};

  // A counter only runs while the synchronised level disagrees with the
  // accepted one; any agreeing cycle throws the partial count away.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1))
          deb_d[i] = sync2_q[i];
        else
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = IDLE;
    hp_cnt_d = hp_cnt_q;
    phase_d  = phase_q;
    tick_d   = 1'b0;

    if (deb_q[2])
      state_d = HAZARD;
    else if (deb_q[0] && !deb_q[1])
      state_d = LEFT;
    else if (deb_q[1] && !deb_q[0])
      state_d = RIGHT;

    // Lamps and phase are derived from the next state so they change on the
    // same edge as mode, including the forced-off transition into IDLE.
    if (state_d != state_q) begin
      hp_cnt_d = '0;
      phase_d  = (state_d != IDLE);
    end else if (state_q != IDLE) begin
      if (hp_cnt_q == HP_W'(HALF_PERIOD - 1)) begin
        hp_cnt_d = '0;
        phase_d  = ~phase_q;
        tick_d   = 1'b1;
      end else begin
        hp_cnt_d = hp_cnt_q + HP_W'(1);
      end
    end else begin
      hp_cnt_d = '0;
      phase_d  = 1'b0;
    end

    tl_d = phase_d && ((state_d == LEFT)  || (state_d == HAZARD));
    tr_d = phase_d && ((state_d == RIGHT) || (state_d == HAZARD));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      db_cnt_q <= '0;
      state_q  <= IDLE;
      hp_cnt_q <= '0;
      phase_q  <= 1'b0;
      tick_q   <= 1'b0;
      tl_q     <= 1'b0;
      tr_q     <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      hp_cnt_q <= hp_cnt_d;
      phase_q  <= phase_d;
      tick_q   <= tick_d;
      tl_q     <= tl_d;
      tr_q     <= tr_d;
    end
  end

  assign bus.turn_left  = tl_q;
  assign bus.turn_right = tr_q;
  assign bus.tick       = tick_q;
  assign bus.mode       = state_q;

endmodule

// File: tb/tb_turn_signal_controller.sv
// Bench for turn_signal_controller: directed scenarios plus random switch
// activity, compared every cycle against an edge-counting behavioural model.
module tb_turn_signal_controller;

  localparam int unsigned D  = 4;
  localparam int unsigned HP = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          live_chk = 1'b0;

  turn_signal_controller_if bus ();

  turn_signal_controller #(
    .DEBOUNCE_CYC (D),
    .HALF_PERIOD  (HP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
  endtask

  // Reference model: debounced level flips once the last D synchronised
  // samples all disagree with it; blink output is pure arithmetic on the
  // number of edges elapsed since the current lit mode was entered.
  bit          hist [3][0:D+1];
  bit          m_deb [3];
  int          m_mode;
  int unsigned m_e, m_entry;
  bit          m_phase, m_tick, m_tl, m_tr;

  function automatic int prio(bit l, bit r, bit h);
    if (h) return 3;
    if (l && !r) return 1;
    if (r && !l) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_deb[i] = 1'b0;
        for (int k = 0; k <= D + 1; k++) hist[i][k] = 1'b0;
      end
      m_mode = 0; m_e = 0; m_entry = 0;
      m_phase = 1'b0; m_tick = 1'b0; m_tl = 1'b0; m_tr = 1'b0;
    end else begin
      int nm;
      bit raw [3];
      m_e++;
      raw[0] = bus.sw_turn_left;
      raw[1] = bus.sw_turn_right;
      raw[2] = bus.sw_hazard;
      for (int i = 0; i < 3; i++) begin
        for (int k = D + 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = raw[i];
      end
      nm = prio(m_deb[0], m_deb[1], m_deb[2]);
      for (int i = 0; i < 3; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 2; k <= D + 1; k++)
          if (hist[i][k] == m_deb[i]) all_diff = 1'b0;
        if (all_diff) m_deb[i] = ~m_deb[i];
      end
      if (nm != m_mode && nm != 0) m_entry = m_e;
      m_mode = nm;
      if (m_mode == 0) begin
        m_phase = 1'b0;
        m_tick  = 1'b0;
      end else begin
        int unsigned el;
        el      = m_e - m_entry;
        m_phase = ((el / HP) % 2) == 0;
        m_tick  = (el != 0) && (el % HP == 0);
      end
      m_tl = m_phase && (m_mode == 1 || m_mode == 3);
      m_tr = m_phase && (m_mode == 2 || m_mode == 3);
    end
  end

  always @(negedge clk) begin
    if (rst && live_chk) begin
      check_eq("mode",       32'(bus.mode),       32'(m_mode));
      check_eq("turn_left",  32'(bus.turn_left),  32'(m_tl));
      check_eq("turn_right", 32'(bus.turn_right), 32'(m_tr));
      check_eq("tick",       32'(bus.tick),       32'(m_tick));
    end
  end

  task automatic set_sw(input bit l, input bit r, input bit h);
    bus.sw_turn_left  = l;
    bus.sw_turn_right = r;
    bus.sw_hazard     = h;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    set_sw(0, 0, 0);
    #12;
    check_eq("rst_mode", 32'(bus.mode), 32'd0);
    check_eq("rst_lamps", 32'({bus.turn_left, bus.turn_right, bus.tick}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    live_chk = 1'b1;
    run(3);

    // Left blink with explicit D+3 latency boundary.
    set_sw(1, 0, 0);
    repeat (D + 2) @(posedge clk);
    #1 check_eq("lat_before", 32'(bus.mode), 32'd0);
    @(posedge clk);
    #1 check_eq("lat_mode", 32'(bus.mode), 32'd1);
    check_eq("lat_lamp", 32'(bus.turn_left), 32'd1);
    run(40);
    set_sw(0, 0, 0);
    run(15);

    // Glitch shorter than the debounce window.
    set_sw(0, 0, 1);
    run(3);
    set_sw(0, 0, 0);
    run(20);

    // Hazard raised while left is in its OFF phase, then dropped.
    set_sw(1, 0, 0);
    run(D + 4);
    for (int n = 0; n < 40 && !(m_mode == 1 && !m_phase); n++) @(negedge clk);
    check_eq("left_off_reached", 32'(m_mode == 1 && !m_phase), 32'd1);
    set_sw(1, 0, 1);
    run(30);
    set_sw(1, 0, 0);
    run(30);

    // Conflict, then release right.
    set_sw(1, 1, 0);
    run(20);
    set_sw(1, 0, 0);
    run(20);

    // Direct swap left -> right.
    set_sw(0, 1, 0);
    run(30);
    set_sw(0, 0, 0);
    run(12);

    // Random switch activity with random hold times around the debounce window.
    repeat (60) begin
      set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      run($urandom_range(1, 14));
    end
    set_sw(0, 0, 0);
    run(12);

    // Async reset during hazard ON phase.
    set_sw(0, 0, 1);
    run(D + 4);
    for (int n = 0; n < 40 && !(m_mode == 3 && m_phase); n++) @(negedge clk);
    check_eq("haz_on_reached", 32'(m_mode == 3 && m_phase), 32'd1);
    check_eq("haz_on_dut", 32'({bus.turn_left, bus.turn_right}), 32'd3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("async_lamps", 32'({bus.turn_left, bus.turn_right, bus.tick}), 32'd0);
    check_eq("async_mode", 32'(bus.mode), 32'd0);
    repeat (3) @(posedge clk);
    #1 check_eq("held_rst_mode", 32'(bus.mode), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run(30);

    live_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
